// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and defaults for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PARITY_NONE          = 0;
  localparam int PARITY_ODD           = 1;
  localparam int PARITY_EVEN          = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Odd mode returns the XNOR reduction, every other mode the XOR reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, ticks on the last clock of each serial bit
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a show-ahead FIFO and sends them as UART frames
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 4");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_tx;
  logic       r_tx_done;

  tx_state_t  w_state_nxt;
  logic [7:0] w_shift_nxt;
  logic [2:0] w_bit_idx_nxt;
  logic [2:0] w_idx_inc;
  logic       w_stop_idx_nxt;
  logic       w_tx_nxt;
  logic       w_done_nxt;
  logic       w_clear;
  logic       w_rd_en;
  logic       w_bit_end;

  // Counter is held clear through IDLE and LOAD so START gets a full bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (w_clear),
    .o_bit_end(w_bit_end)
  );

  assign w_idx_inc  = r_bit_idx + 3'd1;
  assign fifo_rd_en = w_rd_en;
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE);
  assign tx_done    = r_tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_clear        = 1'b0;
    w_rd_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_clear  = 1'b1;
        w_tx_nxt = 1'b1;
        if (enable && !fifo_empty) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_clear     = 1'b1;
        w_rd_en     = 1'b1;
        w_shift_nxt = fifo_rd_data;
        w_tx_nxt    = 1'b0;
        w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_tx_nxt      = r_shift[0];
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_stop_idx_nxt = 1'b0;
            if (PARITY != PARITY_NONE) begin
              w_tx_nxt    = parity_bit(r_shift, PARITY);
              w_state_nxt = ST_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = ST_STOP;
            end
          end else begin
            w_bit_idx_nxt = w_idx_inc;
            w_tx_nxt      = r_shift[w_idx_inc];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_tx_nxt       = 1'b1;
          w_stop_idx_nxt = 1'b0;
          w_state_nxt    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == 1'(STOP_BITS - 1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench: four parameterisations of fifo_uart_tx, each fed by a show-ahead 16x8 FIFO
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int NCH = 4;
  localparam int CPB = 4;
  localparam int PAR_C [NCH] = '{0, 2, 1, 0};
  localparam int STP_C [NCH] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           fifo_rst;
  logic [NCH-1:0] dut_rst;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] wr_en;
  logic [7:0]     wr_data;
  logic [NCH-1:0] empty_v, rd_en_v, tx_v, busy_v, done_v;
  logic [7:0]     rd_data_v [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [7:0] mem [16];
    logic [4:0] wp, rp;
    logic       empty_r;

    // Empty is registered from the pointers, so it trails any pointer move by one cycle.
    always @(posedge clk) begin
      if (fifo_rst) begin
        wp      <= '0;
        rp      <= '0;
        empty_r <= 1'b1;
      end else begin
        if (wr_en[g]) begin
          mem[wp[3:0]] <= wr_data;
          wp           <= wp + 5'd1;
        end
        if (rd_en_v[g]) rp <= rp + 5'd1;
        empty_r <= (wp == rp);
      end
    end

    assign empty_v[g]   = empty_r;
    assign rd_data_v[g] = mem[rp[3:0]];

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR_C[g]),
      .STOP_BITS   (STP_C[g])
    ) u_dut (
      .clk         (clk),
      .rst         (dut_rst[g]),
      .enable      (enable[g]),
      .fifo_empty  (empty_v[g]),
      .fifo_rd_data(rd_data_v[g]),
      .fifo_rd_en  (rd_en_v[g]),
      .tx          (tx_v[g]),
      .busy        (busy_v[g]),
      .tx_done     (done_v[g])
    );
  end

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pop_viol = 0;
  int   rd_cnt   [NCH] = '{default: 0};
  int   done_cnt [NCH] = '{default: 0};
  int   last_gap [NCH] = '{default: 0};
  int   k        [NCH] = '{default: -1};
  int   hi_run   [NCH] = '{default: 0};
  logic [11:0] rec    [NCH];
  logic        glitch [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int head_of(input int ch);
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].ch == ch) return j;
    end
    return -1;
  endfunction

  // Expected byte and hand-computed parity bit go on the scoreboard at write time.
  task automatic push(input int ch, input logic [7:0] d, input logic p);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    e.p  = p;
    exp_q.push_back(e);
    wr_data    = d;
    wr_en[ch]  = 1'b1;
    @(posedge clk); #1;
    wr_en[ch]  = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int target);
    int n = 0;
    while (done_cnt[ch] < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("ch%0d frame %0d completes", ch, target), 32'(done_cnt[ch] >= target), 32'd1);
  endtask

  task automatic wait_fall(input int ch);
    int n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (tx_v[ch] == 1'b0) break;
    end
    check($sformatf("ch%0d tx falls", ch), 32'(tx_v[ch]), 32'd0);
  endtask

  // Monitor: rebuilds each frame from the line, checks bit widths, tx_done timing and content.
  always @(negedge clk) begin
    int nbits, len, h;
    logic [11:0] want;
    for (int i = 0; i < NCH; i++) begin
      nbits = 9 + ((PAR_C[i] != 0) ? 1 : 0) + STP_C[i];
      len   = nbits * CPB;
      if (dut_rst[i]) begin
        if (k[i] >= 0) begin
          h = head_of(i);
          if (h >= 0) exp_q.delete(h);
        end
        k[i]      = -1;
        hi_run[i] = 0;
      end else begin
        if (rd_en_v[i]) begin
          rd_cnt[i]++;
          if (empty_v[i] !== 1'b0) pop_viol++;
        end
        if (done_v[i] === 1'b1) done_cnt[i]++;
        if (k[i] < 0 && tx_v[i] == 1'b0) begin
          last_gap[i] = hi_run[i];
          k[i]        = 0;
          rec[i]      = '1;
          glitch[i]   = 1'b0;
        end
        if (k[i] < 0) begin
          hi_run[i]++;
        end else if (k[i] < len) begin
          if (k[i] % CPB == 0) rec[i][k[i] / CPB] = tx_v[i];
          else if (tx_v[i] !== rec[i][k[i] / CPB]) glitch[i] = 1'b1;
          if (done_v[i] !== 1'b0) glitch[i] = 1'b1;
          k[i]++;
        end else begin
          check($sformatf("ch%0d tx_done %0d cycles after fall", i, len), 32'(done_v[i]), 32'd1);
          h = head_of(i);
          check($sformatf("ch%0d frame was expected", i), 32'(h >= 0), 32'd1);
          if (h >= 0) begin
            want    = '1;
            want[0] = 1'b0;
            want[8:1] = exp_q[h].d;
            if (PAR_C[i] != 0) want[9] = exp_q[h].p;
            check($sformatf("ch%0d frame bits (glitch flag in bit 12) for 0x%02h", i, exp_q[h].d),
                  32'({glitch[i], rec[i]}), 32'({1'b0, want}));
            exp_q.delete(h);
          end
          k[i]      = -1;
          hi_run[i] = STP_C[i] * CPB + 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_rst = 1'b1;
    dut_rst  = '1;
    enable   = '0;
    wr_en    = '0;
    wr_data  = '0;

    // 1: reset state and no pops from an empty FIFO
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("ch%0d reset {tx,rd_en,busy,tx_done}", i),
            32'({tx_v[i], rd_en_v[i], busy_v[i], done_v[i]}), 32'b1000);
    end
    fifo_rst = 1'b0;
    dut_rst  = '0;
    enable   = '1;
    repeat (10) @(posedge clk);
    #1;
    check("pops while FIFO empty", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), 32'd0);
    check("busy while FIFO empty", 32'(busy_v), 32'd0);

    // 2: 0xA5, no parity, one stop bit
    push(0, 8'hA5, 1'b0);
    wait_done(0, 1);
    check("ch0 pops after 0xA5", 32'(rd_cnt[0]), 32'd1);

    // 3: 0x07 with even parity (bit 1) and odd parity (bit 0)
    push(1, 8'h07, 1'b1);
    push(2, 8'h07, 1'b0);
    wait_done(1, 1);
    wait_done(2, 1);

    // 4: back-to-back 0x55, 0xAA with two stop bits
    push(3, 8'h55, 1'b0);
    push(3, 8'hAA, 1'b0);
    wait_done(3, 2);
    check("ch3 pops for two bytes", 32'(rd_cnt[3]), 32'd2);
    check("ch3 line high between frames", 32'(last_gap[3]), 32'd10);
    check("ch3 FIFO empty at end", 32'(empty_v[3]), 32'd1);

    // 5: enable dropped during DATA bit 3 of 0x3C
    push(0, 8'h3C, 1'b0);
    push(0, 8'h81, 1'b0);
    wait_fall(0);
    repeat (17) @(posedge clk);
    #1;
    enable[0] = 1'b0;
    wait_done(0, 2);
    repeat (20) @(posedge clk);
    #1;
    check("ch0 idle while disabled", 32'(busy_v[0]), 32'd0);
    check("ch0 no pop while disabled", 32'(rd_cnt[0]), 32'd2);
    check("ch0 FIFO still holds 0x81", 32'(empty_v[0]), 32'd0);
    enable[0] = 1'b1;
    wait_done(0, 3);
    check("ch0 pops after re-enable", 32'(rd_cnt[0]), 32'd3);

    // 6: reset during DATA bit 5 of 0x96
    push(0, 8'h96, 1'b0);
    push(0, 8'h12, 1'b0);
    push(0, 8'h34, 1'b0);
    wait_fall(0);
    repeat (25) @(posedge clk);
    #1;
    dut_rst[0] = 1'b1;
    @(posedge clk);
    #1;
    dut_rst[0] = 1'b0;
    check("ch0 {tx,busy} after mid-frame reset", 32'({tx_v[0], busy_v[0]}), 32'b10);
    wait_done(0, 5);
    check("ch0 total pops", 32'(rd_cnt[0]), 32'd6);
    check("ch0 FIFO empty at end", 32'(empty_v[0]), 32'd0 + 32'd1);

    repeat (20) @(posedge clk);
    #1;
    check("pops issued while empty", 32'(pop_viol), 32'd0);
    check("scoreboard entries left", 32'(exp_q.size()), 32'd0);
    check("ch0 tx_done cycles", 32'(done_cnt[0]), 32'd5);
    check("ch1 tx_done cycles", 32'(done_cnt[1]), 32'd1);
    check("ch2 tx_done cycles", 32'(done_cnt[2]), 32'd1);
    check("ch3 tx_done cycles", 32'(done_cnt[3]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
